multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle processor control unit: Moore FSM sequencing fetch/decode/execute
// plus the stored NZCV flags register and conditional-execution check.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] alu_flags,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic       alu_srcA,
    output logic [1:0] alu_srcB,
    output logic [2:0] alu_op,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       reg_A2src,
    output logic [3:0] flags,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [3:0] CMD_CMP = 4'b1010;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_flags;

    logic       w_imm_bit;
    logic [3:0] w_cmd;
    logic       w_set_bit;
    logic       w_cond_base;
    logic       w_cond_ok;
    logic [2:0] w_cmd_aluop;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;

    assign w_imm_bit = funct[5];
    assign w_cmd     = funct[4:1];
    assign w_set_bit = funct[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Flags only change at the end of an execute step that requested them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if ((r_state == S_EXECUTER || r_state == S_EXECUTEI) &&
                     (w_set_bit || w_cmd == CMD_CMP)) begin
            r_flags <= alu_flags;
        end
    end

    // Odd condition codes are the complement of the even code below them.
    always_comb begin
        w_cond_base = 1'b1;
        case (cond[3:1])
            3'd0: w_cond_base = r_flags[2];
            3'd1: w_cond_base = r_flags[1];
            3'd2: w_cond_base = r_flags[3];
            3'd3: w_cond_base = r_flags[0];
            3'd4: w_cond_base = r_flags[1] & ~r_flags[2];
            3'd5: w_cond_base = (r_flags[3] == r_flags[0]);
            3'd6: w_cond_base = ~r_flags[2] & (r_flags[3] == r_flags[0]);
            default: w_cond_base = 1'b1;
        endcase
        w_cond_ok = cond[0] ? ~w_cond_base : w_cond_base;
    end

    always_comb begin
        w_cmd_aluop = 3'b000;
        case (w_cmd)
            4'b0100: w_cmd_aluop = 3'b000;
            4'b0010: w_cmd_aluop = 3'b001;
            4'b0000: w_cmd_aluop = 3'b010;
            4'b1100: w_cmd_aluop = 3'b011;
            4'b1010: w_cmd_aluop = 3'b001;
            4'b1101: w_cmd_aluop = 3'b100;
            default: w_cmd_aluop = 3'b000;
        endcase
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        adr_src     = 1'b0;
        alu_srcA    = 1'b0;
        alu_srcB    = 2'b00;
        alu_op      = 3'b000;
        result_src  = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                alu_srcA   = 1'b1;
                alu_srcB   = 2'b10;
                result_src = 2'b10;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                alu_srcA = 1'b1;
                alu_srcB = 2'b10;
                if (!w_cond_ok) begin
                    w_next = S_FETCH;
                end else begin
                    case (op)
                        2'b01:   w_next = S_MEMADR;
                        2'b00:   w_next = w_imm_bit ? S_EXECUTEI : S_EXECUTER;
                        2'b10:   w_next = S_BRANCH;
                        default: w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_srcB = 2'b01;
                w_next   = w_set_bit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                w_next  = S_MEMWB;
            end
            // Address stays on the ALU result register through write-back.
            S_MEMWB: begin
                adr_src     = 1'b1;
                result_src  = 2'b01;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                alu_srcB = (r_state == S_EXECUTEI) ? 2'b01 : 2'b00;
                alu_op   = w_cmd_aluop;
                w_next   = (w_cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                alu_srcB   = 2'b01;
                result_src = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset forces every write enable low even though FETCH would assert some.
    assign pc_write  = w_pc_write  & rst_n;
    assign ir_write  = w_ir_write  & rst_n;
    assign reg_write = w_reg_write & rst_n;
    assign mem_write = w_mem_write & rst_n;

    always_comb begin
        imm_src = 2'b00;
        case (op)
            2'b01:   imm_src = 2'b01;
            2'b10:   imm_src = 2'b10;
            default: imm_src = 2'b00;
        endcase
    end

    assign reg_A2src = (op == 2'b01) && !funct[0];
    assign flags     = r_flags;
    assign state     = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each issued instruction pushes its
// expected per-cycle behaviour; a negedge monitor pops and compares.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] alu_flags;
    logic       pc_write, ir_write, reg_write, mem_write;
    logic       adr_src, alu_srcA;
    logic [1:0] alu_srcB;
    logic [2:0] alu_op;
    logic [1:0] result_src, imm_src;
    logic       reg_A2src;
    logic [3:0] flags, state;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] we;
        logic       adr;
        logic       adrCare;
        logic       srcA;
        logic [1:0] srcB;
        logic [2:0] aluop;
        logic [1:0] res;
        logic [1:0] imm;
        logic       a2;
        logic [3:0] fl;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;

    logic [3:0] modelFlags;
    logic [1:0] stepImm;
    logic       stepA2;
    logic       stepAdrCare;
    int         stepCount;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct),
        .alu_flags(alu_flags), .pc_write(pc_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_write(mem_write), .adr_src(adr_src),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_op(alu_op),
        .result_src(result_src), .imm_src(imm_src), .reg_A2src(reg_A2src),
        .flags(flags), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic condPass(input logic [3:0] c, input logic [3:0] fl);
        logic n, z, cy, v;
        logic table16 [16];
        {n, z, cy, v} = fl;
        table16[0]  = z;            table16[1]  = !z;
        table16[2]  = cy;           table16[3]  = !cy;
        table16[4]  = n;            table16[5]  = !n;
        table16[6]  = v;            table16[7]  = !v;
        table16[8]  = cy && !z;     table16[9]  = !cy || z;
        table16[10] = n == v;       table16[11] = n != v;
        table16[12] = !z && n == v; table16[13] = z || n != v;
        table16[14] = 1'b1;         table16[15] = 1'b0;
        return table16[c];
    endfunction

    function automatic logic [2:0] aluOpFor(input logic [3:0] cmd);
        case (cmd)
            4'd4:    return 3'd0;
            4'd2:    return 3'd1;
            4'd0:    return 3'd2;
            4'd12:   return 3'd3;
            4'd10:   return 3'd1;
            4'd13:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    task automatic pushStep(input logic [3:0] st, input logic [3:0] we, input logic adr,
                            input logic srcA, input logic [1:0] srcB,
                            input logic [2:0] aluop, input logic [1:0] res);
        exp_t e;
        e.st = st; e.we = we; e.adr = adr; e.adrCare = stepAdrCare;
        e.srcA = srcA; e.srcB = srcB; e.aluop = aluop; e.res = res;
        e.imm = stepImm; e.a2 = stepA2; e.fl = modelFlags;
        expQ.push_back(e);
        stepCount++;
        stepAdrCare = 1'b1;
    endtask

    // Issue one instruction at the start of a FETCH cycle; enables are {pc,ir,reg,mem}.
    task automatic applyStimulus(input logic [3:0] c, input logic [1:0] o,
                                 input logic [5:0] f, input logic [3:0] af);
        logic [3:0] cmd;
        logic       pass;
        cmd  = f[4:1];
        pass = condPass(c, modelFlags);
        stepImm     = (o == 2'b01) ? 2'b01 : (o == 2'b10) ? 2'b10 : 2'b00;
        stepA2      = (o == 2'b01) && !f[0];
        stepAdrCare = 1'b1;
        stepCount   = 0;
        cond = c; op = o; funct = f; alu_flags = af;
        pushStep(4'd0, 4'b1100, 1'b0, 1'b1, 2'b10, 3'd0, 2'b10);
        pushStep(4'd1, 4'b0000, 1'b0, 1'b1, 2'b10, 3'd0, 2'b00);
        if (pass && o == 2'b01) begin
            pushStep(4'd2, 4'b0000, 1'b0, 1'b0, 2'b01, 3'd0, 2'b00);
            if (f[0]) begin
                pushStep(4'd3, 4'b0000, 1'b1, 1'b0, 2'b00, 3'd0, 2'b00);
                stepAdrCare = 1'b0;
                pushStep(4'd4, 4'b0010, 1'b0, 1'b0, 2'b00, 3'd0, 2'b01);
            end else begin
                pushStep(4'd5, 4'b0001, 1'b1, 1'b0, 2'b00, 3'd0, 2'b00);
            end
        end else if (pass && o == 2'b10) begin
            pushStep(4'd9, 4'b1000, 1'b0, 1'b0, 2'b01, 3'd0, 2'b10);
        end else if (pass && o == 2'b00) begin
            pushStep(f[5] ? 4'd7 : 4'd6, 4'b0000, 1'b0, 1'b0,
                     f[5] ? 2'b01 : 2'b00, aluOpFor(cmd), 2'b00);
            if (f[0] || cmd == 4'd10) modelFlags = af;
            if (cmd != 4'd10) pushStep(4'd8, 4'b0010, 1'b0, 1'b0, 2'b00, 3'd0, 2'b00);
        end
        repeat (stepCount) @(posedge clk);
        #2;
    endtask

    task automatic checkOutput();
        exp_t e;
        e = expQ.pop_front();
        checkVal($sformatf("state(exp %0d)", e.st), {28'd0, state}, {28'd0, e.st});
        checkVal($sformatf("enables(state %0d)", e.st),
                 {28'd0, pc_write, ir_write, reg_write, mem_write}, {28'd0, e.we});
        checkVal($sformatf("datapath(state %0d)", e.st),
                 {18'd0, adr_src | ~e.adrCare, alu_srcA, alu_srcB, alu_op, result_src, imm_src, reg_A2src},
                 {18'd0, e.adr | ~e.adrCare, e.srcA, e.srcB, e.aluop, e.res, e.imm, e.a2});
        checkVal($sformatf("flags(state %0d)", e.st), {28'd0, flags}, {28'd0, e.fl});
    endtask

    always @(negedge clk) begin
        if (rst_n && expQ.size() > 0) checkOutput();
    end

    initial begin
        logic [3:0] cmds [7];
        logic       found;
        logic [3:0] rc;
        logic [5:0] rf;
        cmds = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd10, 4'd13, 4'd7};
        rst_n = 1'b0; cond = 4'd0; op = 2'd0; funct = 6'd0; alu_flags = 4'd0;
        modelFlags = 4'd0;
        #1;
        checkVal("resetState", {28'd0, state}, 32'd0);
        checkVal("resetFlags", {28'd0, flags}, 32'd0);
        checkVal("resetEnables", {28'd0, pc_write, ir_write, reg_write, mem_write}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        applyStimulus(4'b0000, 2'b10, 6'b000000, 4'b0000);
        applyStimulus(4'b1110, 2'b00, 6'b001001, 4'b0100);
        applyStimulus(4'b0000, 2'b10, 6'b000000, 4'b0000);
        applyStimulus(4'b1110, 2'b01, 6'b000001, 4'b1111);
        applyStimulus(4'b1110, 2'b01, 6'b000000, 4'b1111);
        applyStimulus(4'b1110, 2'b00, 6'b010100, 4'b1001);
        applyStimulus(4'b1111, 2'b00, 6'b001001, 4'b0110);
        applyStimulus(4'b1110, 2'b11, 6'b000000, 4'b0000);
        applyStimulus(4'b1110, 2'b00, 6'b111011, 4'b0011);

        for (int i = 0; i < 250; i++) begin
            rc = ($urandom_range(0, 2) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
            rf = 6'($urandom_range(0, 63));
            rf[4:1] = cmds[$urandom_range(0, 6)];
            applyStimulus(rc, 2'($urandom_range(0, 3)), rf, 4'($urandom_range(0, 15)));
        end

        applyStimulus(4'b1110, 2'b00, 6'b010100, 4'b1111);
        cond = 4'b1110; op = 2'b01; funct = 6'b000000;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(posedge clk);
            #2;
            if (state == 4'd5) found = 1'b1;
        end
        checkVal("reachMemwrite", {31'd0, found}, 32'd1);
        checkVal("memwriteEnable", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkVal("abortState", {28'd0, state}, 32'd0);
        checkVal("abortEnables", {28'd0, pc_write, ir_write, reg_write, mem_write}, 32'd0);
        checkVal("abortFlags", {28'd0, flags}, 32'd0);
        @(posedge clk);
        #2;
        checkVal("heldResetEnables", {28'd0, pc_write, ir_write, reg_write, mem_write}, 32'd0);
        rst_n = 1'b1;
        modelFlags = 4'd0;
        applyStimulus(4'b1110, 2'b00, 6'b101001, 4'b0101);
        applyStimulus(4'b0101, 2'b10, 6'b000000, 4'b0000);

        checkVal("queueDrained", expQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
